tm1638_sequencer: RTL and testbench

TM1638_SEQUENCER -- requirements
Module: tm1638_sequencer

---
 rtl/tm1638_sequencer.sv | 136 +++++++++++++
 tb/tb_tm1638_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_sequencer.sv
// tm1638_sequencer: drives a TM1638 through a generic SPI-style controller,
// sending mode/data/control commands each frame and reading back the key scan.
`default_nettype none

module tm1638_sequencer #(
  parameter int NUM_SELECTS    = 2,
  parameter int CS_INDEX       = 0,
  parameter int POWERUP_CYCLES = 500000,
  parameter int REFRESH_CYCLES = 500000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             display_data [16],
  input  logic [2:0]             brightness,
  input  logic                   display_on,
  output logic [31:0]            keys,
  output logic                   keys_valid,
  output logic                   frame_done,
  input  logic                   spi_busy,
  output logic                   spi_activate,
  output logic [NUM_SELECTS-1:0] spi_in_cs,
  output logic [7:0]             spi_out_data [17],
  output logic [4:0]             spi_out_count,
  output logic [2:0]             spi_in_count,
  input  logic [7:0]             spi_in_data [4]
);

  localparam int PW_W = $clog2(POWERUP_CYCLES + 1);
  localparam int FR_W = $clog2(REFRESH_CYCLES + 1);
  localparam logic [NUM_SELECTS-1:0] CS_ONEHOT = NUM_SELECTS'(1) << CS_INDEX;

  typedef enum logic [2:0] {
    S_POWERUP, S_WAIT, S_MODE, S_DATA, S_CTRL, S_READ, S_LATCH
  } state_t;

  state_t                   state_q, next_d;
  logic [PW_W-1:0]          pwr_cnt_q;
  logic [FR_W-1:0]          frame_cnt_q;
  logic                     activate_q, seen_q, launch_d, txn_done_d;
  logic [NUM_SELECTS-1:0]   cs_q;
  logic [7:0]               out_data_q [17];
  logic [7:0]               tx_data_d  [17];
  logic [4:0]               out_cnt_q, tx_out_cnt_d;
  logic [2:0]               in_cnt_q, tx_in_cnt_d;
  logic [31:0]              keys_q;
  logic                     keys_valid_q, frame_done_q;

  // A transaction is finished once busy was seen high and has fallen again.
  assign txn_done_d = seen_q && !activate_q && !spi_busy;

  always_comb begin
    launch_d = 1'b0;
    next_d   = state_q;
    case (state_q)
      S_POWERUP: if (pwr_cnt_q == '0 && !spi_busy) begin launch_d = 1'b1; next_d = S_MODE; end
      S_WAIT:    if (frame_cnt_q == '0 && !spi_busy) begin launch_d = 1'b1; next_d = S_MODE; end
      S_MODE:    if (txn_done_d) begin launch_d = 1'b1; next_d = S_DATA; end
      S_DATA:    if (txn_done_d) begin launch_d = 1'b1; next_d = S_CTRL; end
      S_CTRL:    if (txn_done_d) begin launch_d = 1'b1; next_d = S_READ; end
      S_READ:    if (txn_done_d) next_d = S_LATCH;
      S_LATCH:   next_d = S_WAIT;
      default:   next_d = S_POWERUP;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 17; i++) tx_data_d[i] = 8'h00;
    tx_out_cnt_d = 5'd0;
    tx_in_cnt_d  = 3'd0;
    case (next_d)
      S_MODE: begin tx_data_d[0] = 8'h40; tx_out_cnt_d = 5'd1; end
      S_DATA: begin
        tx_data_d[0] = 8'hC0;
        for (int i = 0; i < 16; i++) tx_data_d[i+1] = display_data[i];
        tx_out_cnt_d = 5'd17;
      end
      S_CTRL: begin tx_data_d[0] = {4'h8, display_on, brightness}; tx_out_cnt_d = 5'd1; end
      S_READ: begin tx_data_d[0] = 8'h42; tx_out_cnt_d = 5'd1; tx_in_cnt_d = 3'd4; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_POWERUP;
      pwr_cnt_q    <= PW_W'(POWERUP_CYCLES);
      frame_cnt_q  <= '0;
      activate_q   <= 1'b0;
      seen_q       <= 1'b0;
      cs_q         <= '0;
      for (int i = 0; i < 17; i++) out_data_q[i] <= 8'h00;
      out_cnt_q    <= 5'd0;
      in_cnt_q     <= 3'd0;
      keys_q       <= 32'd0;
      keys_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= next_d;
      keys_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      if (state_q == S_POWERUP && pwr_cnt_q != '0) pwr_cnt_q <= pwr_cnt_q - PW_W'(1);
      // Frame period is measured from one frame start to the next.
      if (launch_d && next_d == S_MODE) frame_cnt_q <= FR_W'(REFRESH_CYCLES - 1);
      else if (frame_cnt_q != '0)       frame_cnt_q <= frame_cnt_q - FR_W'(1);
      if (launch_d) begin
        activate_q <= 1'b1;
        seen_q     <= 1'b0;
        cs_q       <= CS_ONEHOT;
        out_data_q <= tx_data_d;
        out_cnt_q  <= tx_out_cnt_d;
        in_cnt_q   <= tx_in_cnt_d;
      end else if (activate_q && spi_busy) begin
        activate_q <= 1'b0;
        seen_q     <= 1'b1;
        cs_q       <= '0;
      end
      if (state_q == S_READ && next_d == S_LATCH) begin
        keys_q       <= {spi_in_data[3], spi_in_data[2], spi_in_data[1], spi_in_data[0]};
        keys_valid_q <= 1'b1;
        frame_done_q <= 1'b1;
      end
    end
  end

  assign spi_activate  = activate_q;
  assign spi_in_cs     = cs_q;
  assign spi_out_data  = out_data_q;
  assign spi_out_count = out_cnt_q;
  assign spi_in_count  = in_cnt_q;
  assign keys          = keys_q;
  assign keys_valid    = keys_valid_q;
  assign frame_done    = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_tm1638_sequencer.sv
// tb_tm1638_sequencer: directed bench with a behavioural SPI controller model.
`default_nettype none

module tb_tm1638_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  display_data [16];
  logic [2:0]  brightness;
  logic        display_on;
  logic [31:0] keys;
  logic        keys_valid, frame_done;
  logic        spi_busy, spi_activate;
  logic [1:0]  spi_in_cs;
  logic [7:0]  spi_out_data [17];
  logic [4:0]  spi_out_count;
  logic [2:0]  spi_in_count;
  logic [7:0]  spi_in_data [4];

  logic busy_force, model_busy, model_en;
  assign spi_busy = busy_force | model_busy;

  tm1638_sequencer #(
    .NUM_SELECTS(2), .CS_INDEX(0), .POWERUP_CYCLES(100), .REFRESH_CYCLES(50)
  ) dut (
    .clk(clk), .reset(reset), .display_data(display_data), .brightness(brightness),
    .display_on(display_on), .keys(keys), .keys_valid(keys_valid), .frame_done(frame_done),
    .spi_busy(spi_busy), .spi_activate(spi_activate), .spi_in_cs(spi_in_cs),
    .spi_out_data(spi_out_data), .spi_out_count(spi_out_count), .spi_in_count(spi_in_count),
    .spi_in_data(spi_in_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [135:0] b;    // bytes at activation, byte0 in LSBs
    logic [135:0] e;    // bytes when busy falls
    logic [4:0]   cnt;
    logic [2:0]   inc;
    logic [7:0]   act;  // negedges with spi_activate high
  } txn_t;

  txn_t log_q[$];
  int   act_started = 0;
  int   total = 0;
  int   bad = 0;
  int   viol = 0;
  logic act_prev = 1'b0;

  function automatic logic [135:0] pack_out();
    logic [135:0] v = '0;
    for (int k = 0; k < 17; k++) v[8*k +: 8] = spi_out_data[k];
    return v;
  endfunction

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frame_done();
    for (int n = 0; n < 3000 && !frame_done; n++) @(negedge clk);
    check("frame_done_seen", frame_done, 1);
  endtask

  task automatic wait_acts(input int n);
    for (int c = 0; c < 3000 && act_started < n; c++) @(negedge clk);
    check("act_started", act_started >= n, 1);
  endtask

  // Controller model: busy rises 7 cycles after activation, held 20+10*count cycles.
  initial begin
    txn_t t;
    logic aborted;
    int   dur;
    model_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (model_en && spi_activate && !reset) begin
        t = '0;
        t.b = pack_out();
        t.cnt = spi_out_count;
        t.inc = spi_in_count;
        t.act = 8'd1;
        act_started++;
        aborted = 1'b0;
        for (int k = 0; k < 7; k++) begin
          @(negedge clk);
          if (reset) begin aborted = 1'b1; break; end
          if (spi_activate) t.act = t.act + 8'd1;
        end
        if (!aborted) begin
          model_busy = 1'b1;
          dur = 20 + 10 * int'(t.cnt);
          for (int k = 0; k < dur; k++) begin
            @(negedge clk);
            if (reset) begin aborted = 1'b1; break; end
            if (spi_activate) t.act = t.act + 8'd1;
          end
          t.e = pack_out();
          model_busy = 1'b0;
          if (!aborted) log_q.push_back(t);
        end
      end
    end
  end

  // Protocol monitor: no activation into a busy controller; cs tracks activate.
  always @(negedge clk) begin
    if (!reset && spi_activate && !act_prev && spi_busy) viol <= viol + 1;
    if (spi_in_cs !== (spi_activate ? 2'b01 : 2'b00)) viol <= viol + 1;
    act_prev <= spi_activate;
  end

  initial begin
    logic [135:0] exp_v;
    logic         early;
    int           gap;
    reset = 1'b1; busy_force = 1'b1; model_en = 1'b0;
    brightness = 3'd5; display_on = 1'b1;
    for (int i = 0; i < 16; i++) display_data[i] = 8'(i);
    spi_in_data[0] = 8'h01; spi_in_data[1] = 8'h20; spi_in_data[2] = 8'h00; spi_in_data[3] = 8'h80;
    repeat (3) @(negedge clk);

    check("rst_activate", spi_activate, 0);
    check("rst_cs", spi_in_cs, 0);
    check("rst_out_count", spi_out_count, 0);
    check("rst_in_count", spi_in_count, 0);
    check("rst_out_data", pack_out(), 0);
    check("rst_keys", keys, 0);
    check("rst_valid_done", {keys_valid, frame_done}, 0);

    // Power-up: count expires at 100 but busy is held high through edge 150.
    reset = 1'b0;
    early = 1'b0;
    for (int i = 1; i <= 150; i++) begin
      @(negedge clk);
      if (spi_activate) early = 1'b1;
    end
    check("pwr_no_early_act", early, 0);
    busy_force = 1'b0; model_en = 1'b1;
    @(negedge clk);
    check("pwr_act_151", spi_activate, 1);
    check("pwr_cs", spi_in_cs, 2'b01);

    // Frame 1
    wait_frame_done();
    check("f1_keys", keys, 32'h80002001);
    check("f1_keys_valid", keys_valid, 1);
    check("f1_log_size", log_q.size(), 4);
    check("f1_mode", {log_q[0].cnt, log_q[0].inc, log_q[0].b}, {5'd1, 3'd0, 136'h40});
    exp_v = '0;
    exp_v[7:0] = 8'hC0;
    for (int k = 1; k <= 16; k++) exp_v[8*k +: 8] = 8'(k - 1);
    check("f1_data", {log_q[1].cnt, log_q[1].inc, log_q[1].b}, {5'd17, 3'd0, exp_v});
    check("f1_ctrl", {log_q[2].cnt, log_q[2].inc, log_q[2].b}, {5'd1, 3'd0, 136'h8D});
    check("f1_read", {log_q[3].cnt, log_q[3].inc, log_q[3].b}, {5'd1, 3'd4, 136'h42});
    check("f1_act_len", {log_q[0].act, log_q[1].act, log_q[2].act, log_q[3].act},
          {8'd8, 8'd8, 8'd8, 8'd8});

    // Frame 2 inputs; frame ran longer than the refresh period so it follows at once.
    for (int i = 0; i < 16; i++) display_data[i] = 8'hA0 + 8'(i);
    brightness = 3'd2; display_on = 1'b0;
    @(negedge clk);
    check("pulse_single", {keys_valid, frame_done}, 0);
    gap = 1;
    while (!spi_activate && gap < 20) begin @(negedge clk); gap++; end
    check("back_to_back_gap", gap, 2);

    wait_acts(6);
    for (int i = 0; i < 16; i++) display_data[i] = 8'h55;
    wait_frame_done();
    exp_v = '0;
    exp_v[7:0] = 8'hC0;
    for (int k = 1; k <= 16; k++) exp_v[8*k +: 8] = 8'hA0 + 8'(k - 1);
    check("f2_data_at_act", log_q[5].b, exp_v);
    check("f2_data_held", log_q[5].e, exp_v);
    check("f2_ctrl", log_q[6].b, 136'h82);
    check("f2_keys_valid", keys_valid, 1);

    // Frame 3: reset while the data transaction is still being activated.
    wait_acts(10);
    check("f3_mid_data", {spi_activate, spi_out_count}, {1'b1, 5'd17});
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_activate_cs", {spi_activate, spi_in_cs}, 0);
    check("mid_rst_counts", {spi_out_count, spi_in_count}, 0);
    check("mid_rst_out_data", pack_out(), 0);
    check("mid_rst_keys", {keys, keys_valid, frame_done}, 0);
    @(negedge clk);
    reset = 1'b0;
    early = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (spi_activate) early = 1'b1;
    end
    check("rewait_no_early", early, 0);
    @(negedge clk);
    check("rewait_act_101", {spi_activate, spi_out_data[0]}, {1'b1, 8'h40});
    check("protocol_violations", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
